// File: rtl/flash_boot_seq.sv
// -----------------------------------------------------------------------------
// flash_boot_seq
//
// Boot-copy sequencer. After reset (boot mode 0) or on a start request, copies
// COPY_WORDS 32-bit words from the SPI flash window into program RAM. It uses
// two Wishbone master ports, one read-only (flash) and one write-only (RAM).
// The CPU is held in reset while a copy is running. o_done feeds the setup
// register's prog-complete input.
//
// Each word is a flash read (RD) followed by a RAM write (WR). Only one port
// has cyc asserted at any time. With zero-wait slaves a word takes 4 clocks.
// A bus cycle that waits TIMEOUT clocks without an ack aborts the copy into ERR.
//
// Ports:
//   i_wb_clk, i_wb_rst        clock, asynchronous active-high reset
//   i_boot_mode               0 = auto-start after reset, 1 = wait for i_start
//   i_start                   single-cycle start/restart request
//   o_busy / o_cpu_hold       copy in progress / CPU held in reset
//   o_done / o_error          sticky completion / timeout-abort flags
//   o_wb_flash_*, i_wb_flash_* flash read master (adr, cyc, rdt, ack)
//   o_wb_ram_*,   i_wb_ram_ack RAM write master (adr, dat, sel, we, cyc, ack)
// -----------------------------------------------------------------------------
module flash_boot_seq #(
    parameter logic [31:0] FLASH_ADDRESS = 32'hc000_0000,
    parameter logic [31:0] RAM_ADDR      = 32'h0000_8000,
    parameter int unsigned COPY_WORDS    = 2048,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_boot_mode,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_cpu_hold,
    output logic [31:0] o_wb_flash_adr,
    output logic        o_wb_flash_cyc,
    input  logic [31:0] i_wb_flash_rdt,
    input  logic        i_wb_flash_ack,
    output logic [31:0] o_wb_ram_adr,
    output logic [31:0] o_wb_ram_dat,
    output logic [3:0]  o_wb_ram_sel,
    output logic        o_wb_ram_we,
    output logic        o_wb_ram_cyc,
    input  logic        i_wb_ram_ack
);

    localparam int unsigned IDX_W = (COPY_WORDS == 0) ? 1 : $clog2(COPY_WORDS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = (COPY_WORDS == 0) ? '0 : IDX_W'(COPY_WORDS - 1);
    // The last waiting cycle: if the counter already holds TIMEOUT-1 and there
    // is still no ack, this cycle brings the wait to TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic [31:0]      data_q,  data_d;
    // High only during the first clock after reset release. The auto-start
    // decision samples i_boot_mode in that cycle alone.
    logic             first_q;
    logic             start;

    // A start is accepted only while no copy is running.
    assign start = ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR)) &&
                   (i_start || (first_q && !i_boot_mode));

    // NOTE: state registers use non-blocking assignments. Every flop then samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            first_q <= 1'b0;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case statement. That way
    // no path leaves one unassigned, and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    idx_d = '0;
                    tmo_d = '0;
                    // A zero-length image completes on the start edge itself.
                    state_d = (COPY_WORDS == 0) ? S_DONE : S_RD;
                end
            end

            S_RD: begin
                // An ack takes priority over an expiring timeout in the same cycle.
                if (i_wb_flash_ack) begin
                    data_d  = i_wb_flash_rdt;
                    tmo_d   = '0;
                    state_d = S_WR;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_WR: begin
                if (i_wb_ram_ack) begin
                    tmo_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register alone. The async reset of
    // state_q therefore drops both cyc lines and all flags at once. Addresses
    // and data read as zero while their cyc is low.
    always_comb begin
        o_busy         = 1'b0;
        o_cpu_hold     = 1'b0;
        o_done         = 1'b0;
        o_error        = 1'b0;
        o_wb_flash_cyc = 1'b0;
        o_wb_flash_adr = '0;
        o_wb_ram_cyc   = 1'b0;
        o_wb_ram_we    = 1'b0;
        o_wb_ram_adr   = '0;
        o_wb_ram_dat   = '0;

        case (state_q)
            S_RD: begin
                o_busy         = 1'b1;
                o_cpu_hold     = 1'b1;
                o_wb_flash_cyc = 1'b1;
                o_wb_flash_adr = FLASH_ADDRESS + 32'({idx_q, 2'b00});
            end
            S_WR: begin
                o_busy       = 1'b1;
                o_cpu_hold   = 1'b1;
                o_wb_ram_cyc = 1'b1;
                o_wb_ram_we  = 1'b1;
                o_wb_ram_adr = RAM_ADDR + 32'({idx_q, 2'b00});
                o_wb_ram_dat = data_q;
            end
            S_DONE:  o_done  = 1'b1;
            S_ERR:   o_error = 1'b1;
            default: ;
        endcase
    end

    // Every write is a full-word write.
    assign o_wb_ram_sel = 4'hf;

endmodule

// File: tb/tb_flash_boot_seq.sv
// -----------------------------------------------------------------------------
// tb_flash_boot_seq
//
// Directed bench for flash_boot_seq. The main instance copies 4 words with
// TIMEOUT=8. A second instance uses COPY_WORDS=0. The flash and RAM slave
// models have a programmable ack delay (1 = zero-wait). The flash can refuse
// to ack word 2. A negedge monitor records RAM writes and counts protocol
// violations.
// -----------------------------------------------------------------------------
module tb_flash_boot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_mode = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, hold;
    logic [31:0] f_adr, f_rdt, r_adr, r_dat;
    logic        f_cyc, f_ack, r_cyc, r_we, r_ack;
    logic [3:0]  r_sel;

    logic        z_boot = 1'b1;
    logic        z_start = 1'b0;
    logic        z_busy, z_done, z_error, z_hold;
    logic [31:0] z_f_adr, z_r_adr, z_r_dat;
    logic        z_f_cyc, z_r_cyc, z_r_we;
    logic [3:0]  z_r_sel;
    logic [31:0] z_f_rdt = 32'h0;
    logic        z_f_ack = 1'b0;
    logic        z_r_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    int f_dly = 1, r_dly = 1;
    bit f_hang = 1'b0;
    int f_cnt, r_cnt;

    int both_err = 0, stab_err = 0, hold_err = 0, sel_err = 0;
    int act_cnt = 0, z_act = 0, wr_cnt = 0;
    logic [31:0] wr_adr [64];
    logic [31:0] wr_dat [64];
    logic        pf_cyc = 1'b0, pr_cyc = 1'b0;
    logic [31:0] pf_adr = '0, pr_adr = '0, pr_dat = '0;

    always #5 clk = ~clk;

    flash_boot_seq #(
        .COPY_WORDS(4),
        .TIMEOUT   (8)
    ) u_dut (
        .i_wb_clk      (clk),
        .i_wb_rst      (rst),
        .i_boot_mode   (boot_mode),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_cpu_hold    (hold),
        .o_wb_flash_adr(f_adr),
        .o_wb_flash_cyc(f_cyc),
        .i_wb_flash_rdt(f_rdt),
        .i_wb_flash_ack(f_ack),
        .o_wb_ram_adr  (r_adr),
        .o_wb_ram_dat  (r_dat),
        .o_wb_ram_sel  (r_sel),
        .o_wb_ram_we   (r_we),
        .o_wb_ram_cyc  (r_cyc),
        .i_wb_ram_ack  (r_ack)
    );

    flash_boot_seq #(
        .COPY_WORDS(0),
        .TIMEOUT   (8)
    ) u_zero (
        .i_wb_clk      (clk),
        .i_wb_rst      (rst),
        .i_boot_mode   (z_boot),
        .i_start       (z_start),
        .o_busy        (z_busy),
        .o_done        (z_done),
        .o_error       (z_error),
        .o_cpu_hold    (z_hold),
        .o_wb_flash_adr(z_f_adr),
        .o_wb_flash_cyc(z_f_cyc),
        .i_wb_flash_rdt(z_f_rdt),
        .i_wb_flash_ack(z_f_ack),
        .o_wb_ram_adr  (z_r_adr),
        .o_wb_ram_dat  (z_r_dat),
        .o_wb_ram_sel  (z_r_sel),
        .o_wb_ram_we   (z_r_we),
        .o_wb_ram_cyc  (z_r_cyc),
        .i_wb_ram_ack  (z_r_ack)
    );

    // Flash image: word i holds 0x11111111 * (i + 1).
    assign f_rdt = 32'h1111_1111 * (((f_adr - 32'hc000_0000) >> 2) + 32'd1);

    // Flash slave: ack after f_dly cycles of cyc, one-cycle ack pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_ack <= 1'b0;
            f_cnt <= 0;
        end else if (!f_cyc || f_ack) begin
            f_ack <= 1'b0;
            f_cnt <= 0;
        end else if (f_hang && f_adr == 32'hc000_0008) begin
            f_cnt <= 0;
        end else if (f_cnt + 1 >= f_dly) begin
            f_ack <= 1'b1;
        end else begin
            f_cnt <= f_cnt + 1;
        end
    end

    // RAM slave, same shape.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_cnt <= 0;
        end else if (!r_cyc || r_ack) begin
            r_ack <= 1'b0;
            r_cnt <= 0;
        end else if (r_cnt + 1 >= r_dly) begin
            r_ack <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1;
        end
    end

    // Bus monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (f_cyc && r_cyc) both_err++;
        if (f_cyc && pf_cyc && f_adr !== pf_adr) stab_err++;
        if (r_cyc && pr_cyc && (r_adr !== pr_adr || r_dat !== pr_dat)) stab_err++;
        if (hold !== busy) hold_err++;
        if (r_sel !== 4'hf || r_we !== r_cyc) sel_err++;
        if (f_cyc || r_cyc) act_cnt++;
        if (z_f_cyc || z_r_cyc) z_act++;
        if (r_cyc && r_ack) begin
            if (wr_cnt < 64) begin
                wr_adr[wr_cnt] = r_adr;
                wr_dat[wr_cnt] = r_dat;
            end
            wr_cnt++;
        end
        pf_cyc = f_cyc;
        pf_adr = f_adr;
        pr_cyc = r_cyc;
        pr_adr = r_adr;
        pr_dat = r_dat;
    end

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (done || error) break;
        end
    endtask

    task automatic wait_cyc(input bit ram, input logic [31:0] adr, input int max,
                            output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (n < max && !found) begin
            @(negedge clk);
            n++;
            found = ram ? (r_cyc && r_adr == adr) : (f_cyc && f_adr == adr);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, hold, f_cyc, r_cyc, r_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy, done, error, hold, f_cyc, r_cyc, r_we});
        end
        checks++;
        if ({f_adr, r_adr, r_dat} !== 96'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h %h %h expected zeros", f_adr, r_adr, r_dat);
        end
        checks++;
        if (r_sel !== 4'hf) begin
            errors++;
            $display("FAIL reset_sel: got %h expected f", r_sel);
        end
        checks++;
        if ({z_busy, z_done, z_error, z_hold} !== 4'b0) begin
            errors++;
            $display("FAIL reset_zero_flags: got %b expected 0000",
                     {z_busy, z_done, z_error, z_hold});
        end
    endtask

    task automatic test_autostart();
        int n;
        int base;
        base = wr_cnt;
        @(negedge clk);
        rst = 1'b0;
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL auto_done: got done=%b error=%b expected done=1 error=0", done, error);
        end
        checks++;
        if (n < 15 || n > 17) begin
            errors++;
            $display("FAIL auto_latency: got %0d cycles expected 15..17", n);
        end
        checks++;
        if (busy !== 1'b0 || hold !== 1'b0) begin
            errors++;
            $display("FAIL auto_release: got busy=%b hold=%b expected 0 0", busy, hold);
        end
        checks++;
        if (wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL auto_wr_count: got %0d expected 4", wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_adr[base+i] !== 32'h8000 + 32'(4 * i) ||
                wr_dat[base+i] !== 32'h1111_1111 * 32'(i + 1)) begin
                errors++;
                $display("FAIL auto_write%0d: got %h/%h expected %h/%h", i,
                         wr_adr[base+i], wr_dat[base+i],
                         32'h8000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
        checks++;
        if (hold_err !== 0 || both_err !== 0) begin
            errors++;
            $display("FAIL auto_hold_bus: got hold_err=%0d both_err=%0d expected 0 0",
                     hold_err, both_err);
        end
    endtask

    task automatic test_wait_states();
        int n;
        int base;
        f_dly = 3;
        r_dly = 5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        rst = 1'b0;
        wait_done(400, n);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ws_done: got %b expected 1", done);
        end
        checks++;
        if (wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL ws_wr_count: got %0d expected 4", wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_adr[base+i] !== 32'h8000 + 32'(4 * i) ||
                wr_dat[base+i] !== 32'h1111_1111 * 32'(i + 1)) begin
                errors++;
                $display("FAIL ws_write%0d: got %h/%h expected %h/%h", i,
                         wr_adr[base+i], wr_dat[base+i],
                         32'h8000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
        checks++;
        if (stab_err !== 0 || both_err !== 0 || sel_err !== 0) begin
            errors++;
            $display("FAIL ws_protocol: got stab=%0d both=%0d sel=%0d expected 0 0 0",
                     stab_err, both_err, sel_err);
        end
        f_dly = 1;
        r_dly = 1;
    endtask

    task automatic test_jtag_start();
        int n;
        int base;
        int a0;
        boot_mode = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = act_cnt;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (act_cnt - a0 !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL jtag_idle: got activity=%0d busy=%b done=%b expected 0 0 0",
                     act_cnt - a0, busy, done);
        end
        base = wr_cnt;
        pulse_start();
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL jtag_busy: got %b expected 1", busy);
        end
        pulse_start();
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL jtag_copy: got done=%b writes=%0d expected 1 4", done, wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_adr[base+i] !== 32'h8000 + 32'(4 * i) ||
                wr_dat[base+i] !== 32'h1111_1111 * 32'(i + 1)) begin
                errors++;
                $display("FAIL jtag_write%0d: got %h/%h expected %h/%h", i,
                         wr_adr[base+i], wr_dat[base+i],
                         32'h8000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int base;
        bit found;
        f_hang = 1'b1;
        base = wr_cnt;
        pulse_start();
        wait_cyc(1'b0, 32'hc000_0008, 100, n, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tmo_reach_word2: got no flash cycle at c0000008 expected one");
        end
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (error) break;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL tmo_latency: got %0d cycles expected 8", n);
        end
        checks++;
        if ({error, done, f_cyc, r_cyc, hold, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL tmo_flags: got %b expected 100000",
                     {error, done, f_cyc, r_cyc, hold, busy});
        end
        f_hang = 1'b0;
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_restart: got error=%b busy=%b expected 0 1", error, busy);
        end
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || wr_cnt - base !== 6) begin
            errors++;
            $display("FAIL tmo_recover: got done=%b writes=%0d expected 1 6", done, wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_adr[base+2+i] !== 32'h8000 + 32'(4 * i) ||
                wr_dat[base+2+i] !== 32'h1111_1111 * 32'(i + 1)) begin
                errors++;
                $display("FAIL tmo_write%0d: got %h/%h expected %h/%h", i,
                         wr_adr[base+2+i], wr_dat[base+2+i],
                         32'h8000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        int n;
        int base;
        bit found;
        boot_mode = 1'b0;
        pulse_start();
        wait_cyc(1'b1, 32'h0000_8004, 100, n, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reach_wr1: got no RAM cycle at 8004 expected one");
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({f_cyc, r_cyc, busy, hold, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async_abort: got %b expected 000000",
                     {f_cyc, r_cyc, busy, hold, done, error});
        end
        @(negedge clk);
        base = wr_cnt;
        rst = 1'b0;
        wait_cyc(1'b0, 32'hc000_0000, 10, n, found);
        checks++;
        if (!found || n !== 1) begin
            errors++;
            $display("FAIL mid_restart_adr: got found=%b after %0d cycles expected c0000000 after 1",
                     found, n);
        end
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL mid_copy: got done=%b writes=%0d expected 1 4", done, wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_adr[base+i] !== 32'h8000 + 32'(4 * i) ||
                wr_dat[base+i] !== 32'h1111_1111 * 32'(i + 1)) begin
                errors++;
                $display("FAIL mid_write%0d: got %h/%h expected %h/%h", i,
                         wr_adr[base+i], wr_dat[base+i],
                         32'h8000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
    endtask

    task automatic test_zero_words();
        @(negedge clk);
        checks++;
        if (z_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got done=%b expected 0", z_done);
        end
        z_start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (z_done !== 1'b1 || z_busy !== 1'b0 || z_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b error=%b expected 1 0 0",
                     z_done, z_busy, z_error);
        end
        @(negedge clk);
        z_start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (z_act !== 0 || z_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_no_bus: got activity=%0d done=%b expected 0 1", z_act, z_done);
        end
    endtask

    initial begin
        test_reset();
        test_autostart();
        test_wait_states();
        test_jtag_start();
        test_timeout();
        test_reset_mid_copy();
        test_zero_words();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flash_boot_seq.md
Name: flash_boot_seq

Overview:
- Boot-copy sequencer: after reset, or on command, copies a fixed-length image word-by-word from the SPI flash window into program RAM over two Wishbone master ports.
- Holds the CPU in reset while copying, then raises a completion flag that drives the setup register's prog-complete input.
- Sits between the flash Wishbone slave and the RAM arbiter, alongside the ROM and setup register.

Parameters:
- FLASH_ADDRESS, 32'hc000_0000, byte base address of the image in the flash window.
- RAM_ADDR, 32'h0000_8000, byte base address of the destination in RAM.
- COPY_WORDS, 2048, number of 32-bit words to copy; 0 is legal.
- TIMEOUT, 1023, maximum cycles a single bus cycle may wait for ack; must be ≥1.

Ports:
- i_wb_clk  in  1  system clock
- i_wb_rst  in  1  reset, asynchronous, active-high
- i_boot_mode  in  1  0 = auto-start copy after reset; 1 = wait for i_start (JTAG boot)
- i_start  in  1  single-cycle start/restart request
- o_busy  out  1  copy in progress
- o_done  out  1  sticky: last copy completed
- o_error  out  1  sticky: last copy aborted on timeout
- o_cpu_hold  out  1  holds the CPU in reset while busy
- o_wb_flash_adr  out  32  flash read address
- o_wb_flash_cyc  out  1  flash read cycle
- i_wb_flash_rdt  in  32  flash read data
- i_wb_flash_ack  in  1  flash ack
- o_wb_ram_adr  out  32  RAM write address
- o_wb_ram_dat  out  32  RAM write data
- o_wb_ram_sel  out  4  constant 4'hf
- o_wb_ram_we  out  1  equals o_wb_ram_cyc
- o_wb_ram_cyc  out  1  RAM write cycle
- i_wb_ram_ack  in  1  RAM ack

Behaviour:
- Reset (async, active-high):
  - state=IDLE; idx=0; timeout counter=0.
  - All outputs 0, except o_wb_ram_sel=4'hf.
- FSM states: IDLE, RD, WR, DONE, ERR.
- Start conditions:
  - Auto-start on the first clock after reset release when i_boot_mode=0 (sampled that cycle only).
  - i_start=1 in IDLE, DONE or ERR starts a copy; it is ignored in RD and WR.
- Copy start:
  - Clears idx, o_done and o_error; sets o_busy and o_cpu_hold.
  - If COPY_WORDS=0, goes to DONE next cycle; otherwise goes to RD.
- RD:
  - o_wb_flash_cyc=1; o_wb_flash_adr = FLASH_ADDRESS + 4*idx (32-bit wrap).
  - On i_wb_flash_ack: latch i_wb_flash_rdt into the data register, drop cyc, go to WR the next cycle.
- WR:
  - o_wb_ram_cyc=we=1; o_wb_ram_adr = RAM_ADDR + 4*idx; o_wb_ram_dat = latched word.
  - On i_wb_ram_ack: drop cyc.
  - If idx = COPY_WORDS-1, go to DONE; else idx+1 and go to RD.
- Bus rules:
  - Each cyc stays asserted until ack, with address and data stable.
  - Never more than one cyc asserted at a time.
  - At least one idle cycle between consecutive cycles on each port.
  - Ack received while the port's cyc=0 is ignored.
- Throughput: minimum 4 clocks per word with zero-wait acks (ack in the cycle after cyc rises).
- Timeout:
  - Counter clears on entering RD or WR and increments each waiting cycle.
  - If it reaches TIMEOUT with no ack, go to ERR: drop cyc, o_error=1, o_busy=0, o_cpu_hold=0.
  - ack and timeout in the same cycle: ack wins.
- DONE: o_done=1, o_busy=0, o_cpu_hold=0; remains until a new start or reset.
- idx width: clog2(COPY_WORDS+1), minimum 1 bit; it never exceeds COPY_WORDS-1.
- Reset mid-copy: immediate abort, both cyc drop asynchronously, no completion flags; auto-start rules apply again after reset release.

Test Plan:
- COPY_WORDS=4, i_boot_mode=0, zero-wait slaves, flash words 0x11111111..0x44444444 -> RAM writes to 0x8000/4/8/C with matching data. o_done rises 16±1 cycles after reset release. o_cpu_hold is high throughout the copy and falls together with o_busy.
- Same, with flash ack delayed 3 cycles and RAM ack delayed 5 -> identical data and addresses; flash_adr stays stable while cyc is high; never two cycs high at once.
- i_boot_mode=1 -> no bus activity for 100 cycles. Then pulse i_start -> copy runs. A second i_start pulse mid-copy is ignored (exactly 4 writes).
- TIMEOUT=8, flash never acks on word 2 -> ERR 8 cycles after cyc rises; o_error=1, o_done=0, cyc=0, o_cpu_hold=0. Then i_start with a healthy slave -> o_error clears and the copy completes.
- Assert i_wb_rst during the WR of word 1 -> cyc and all flags go to 0 in the same cycle. After release with boot_mode=0, the copy restarts from idx 0 at 0xc0000000.
- COPY_WORDS=0 with i_start -> o_done the next cycle; no cyc ever asserted.
